// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data-memory wait FSM encoding, NOP instruction and default counter width.
package cpu_pkg;
  typedef enum logic [0:0] {RUN = 1'b0, WAIT = 1'b1} state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          DEF_CNT_W = 32;
endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Stall-control bundle: hazard unit and branch inputs, data-memory handshake, stage enables, statistics.
interface pipe_stall_ctrl_if
  import cpu_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);
  logic             hz_pcwrite_i;
  logic             hz_stall_i;
  logic             hz_noop_i;
  logic             br_flush_i;
  logic             exmem_memread_i;
  logic             exmem_memwrite_i;
  logic             dmem_ack_i;
  logic             dmem_req_o;
  logic             pc_we_o;
  logic             ifid_we_o;
  logic             ifid_flush_o;
  logic             idex_bubble_o;
  logic             idex_we_o;
  logic             exmem_we_o;
  logic             memwb_we_o;
  logic [CNT_W-1:0] loaduse_cnt_o;
  logic [CNT_W-1:0] memstall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;
  logic             mem_err_o;
  logic             proto_err_o;

  // Driven by the CPU top / hazard unit side.
  modport master (
    output hz_pcwrite_i, hz_stall_i, hz_noop_i, br_flush_i,
           exmem_memread_i, exmem_memwrite_i, dmem_ack_i,
    input  dmem_req_o, pc_we_o, ifid_we_o, ifid_flush_o, idex_bubble_o,
           idex_we_o, exmem_we_o, memwb_we_o,
           loaduse_cnt_o, memstall_cnt_o, flush_cnt_o, mem_err_o, proto_err_o
  );

  // Used by the stall controller itself.
  modport slave (
    input  hz_pcwrite_i, hz_stall_i, hz_noop_i, br_flush_i,
           exmem_memread_i, exmem_memwrite_i, dmem_ack_i,
    output dmem_req_o, pc_we_o, ifid_we_o, ifid_flush_o, idex_bubble_o,
           idex_we_o, exmem_we_o, memwb_we_o,
           loaduse_cnt_o, memstall_cnt_o, flush_cnt_o, mem_err_o, proto_err_o
  );
endinterface

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] q_o
);
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q_o = cnt_q;
endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: resolves hazard, branch and data-memory wait into stage enables,
// and keeps sticky error flags plus saturating stall statistics.
module pipe_stall_ctrl
  import cpu_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int MAX_WAIT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  pipe_stall_ctrl_if.slave  bus
);
  localparam logic [0:0] ST_RUN  = 1'(RUN);
  localparam logic [0:0] ST_WAIT = 1'(WAIT);
  localparam int         WC_W    = $clog2(MAX_WAIT + 1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(MAX_WAIT);
  localparam logic [WC_W-1:0] WC_ONE = WC_W'(1);

  logic [0:0]      state_q, state_d;
  logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            mem_err_q, mem_err_d;
  logic            proto_err_q, proto_err_d;

  logic mem_acc;
  logic mem_stall;
  logic rule_mem, rule_ld, rule_br;
  logic hz_incons;

  assign mem_acc   = bus.exmem_memread_i | bus.exmem_memwrite_i;
  // Reset forces the pipeline to run freely, so no stall rule may fire while rst_i is high.
  assign mem_stall = mem_acc & ~bus.dmem_ack_i & ~rst_i;
  assign rule_mem  = mem_stall;
  assign rule_ld   = ~rst_i & ~mem_stall & bus.hz_stall_i;
  assign rule_br   = ~rst_i & ~mem_stall & ~bus.hz_stall_i & bus.br_flush_i;
  assign hz_incons = (bus.hz_pcwrite_i == bus.hz_stall_i) | (bus.hz_noop_i != bus.hz_stall_i);

  always_comb begin
    bus.dmem_req_o    = mem_acc & ~rst_i;
    bus.pc_we_o       = 1'b1;
    bus.ifid_we_o     = 1'b1;
    bus.ifid_flush_o  = 1'b0;
    bus.idex_bubble_o = 1'b0;
    bus.idex_we_o     = 1'b1;
    bus.exmem_we_o    = 1'b1;
    bus.memwb_we_o    = 1'b1;
    if (rule_mem) begin
      bus.pc_we_o    = 1'b0;
      bus.ifid_we_o  = 1'b0;
      bus.idex_we_o  = 1'b0;
      bus.exmem_we_o = 1'b0;
      bus.memwb_we_o = 1'b0;
    end else if (rule_ld) begin
      // A branch seen alongside a load-use stall depends on the load and resolves again next cycle.
      bus.pc_we_o       = bus.hz_pcwrite_i;
      bus.ifid_we_o     = 1'b0;
      bus.idex_bubble_o = bus.hz_noop_i;
    end else if (rule_br) begin
      bus.ifid_flush_o = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_err_d   = mem_err_q;
    proto_err_d = proto_err_q | hz_incons;
    case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          state_d    = ST_WAIT;
          wait_cnt_d = WC_ONE;
        end
      end
      ST_WAIT: begin
        if (!mem_acc) begin
          state_d     = ST_RUN;
          wait_cnt_d  = '0;
          proto_err_d = 1'b1;
        end else if (bus.dmem_ack_i) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else begin
          // Timeout is only reported; the access keeps waiting for its ack.
          if (wait_cnt_q == WC_MAX) begin
            mem_err_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + WC_ONE;
          end
        end
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      proto_err_q <= proto_err_d;
    end
  end

  logic [2:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_val [3];

  assign cnt_inc = {rule_br, rule_mem, rule_ld};

  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk_i (clk_i),
      .clr_i (rst_i),
      .inc_i (cnt_inc[gi]),
      .q_o   (cnt_val[gi])
    );
  end

  assign bus.loaduse_cnt_o  = cnt_val[0];
  assign bus.memstall_cnt_o = cnt_val[1];
  assign bus.flush_cnt_o    = cnt_val[2];
  assign bus.mem_err_o      = mem_err_q;
  assign bus.proto_err_o    = proto_err_q;
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scenario bench for pipe_stall_ctrl: table-driven rows, expectations queued at drive time, checked on output.
module tb_pipe_stall_ctrl;
  localparam int CNT_W    = 4;
  localparam int MAX_WAIT = 4;

  // Input vector: {rst, pcwrite, stall, noop, br_flush, memread, memwrite, ack}
  localparam logic [7:0] IN_RST      = 8'b1100_0000;
  localparam logic [7:0] IN_RST_RD   = 8'b1100_0100;
  localparam logic [7:0] IN_IDLE     = 8'b0100_0000;
  localparam logic [7:0] IN_LU       = 8'b0011_0000;
  localparam logic [7:0] IN_RD       = 8'b0100_0100;
  localparam logic [7:0] IN_RD_ACK   = 8'b0100_0101;
  localparam logic [7:0] IN_LU_BR    = 8'b0011_1000;
  localparam logic [7:0] IN_LU_BR_RD = 8'b0011_1100;
  localparam logic [7:0] IN_LU_BR_AK = 8'b0011_1101;
  localparam logic [7:0] IN_BR       = 8'b0100_1000;
  localparam logic [7:0] IN_WR_ACK   = 8'b0100_0011;
  localparam logic [7:0] IN_PROTO    = 8'b0111_0000;

  // Output vector: {req, pc_we, ifid_we, ifid_flush, idex_bubble, idex_we, exmem_we, memwb_we}
  localparam logic [7:0] C_IDLE   = 8'b0110_0111;
  localparam logic [7:0] C_LU     = 8'b0000_1111;
  localparam logic [7:0] C_FREEZE = 8'b1000_0000;
  localparam logic [7:0] C_ACK    = 8'b1110_0111;
  localparam logic [7:0] C_LU_ACK = 8'b1000_1111;
  localparam logic [7:0] C_BR     = 8'b0111_0111;
  localparam logic [7:0] C_PROTO  = 8'b0100_1111;

  localparam logic [1:0] K_NONE = 2'd0, K_MEM = 2'd1, K_LU = 2'd2, K_BR = 2'd3;

  typedef struct packed {
    logic [7:0] in_v;
    logic [7:0] exp_c;
    logic [1:0] kind;
    logic       set_me;
    logic       set_pe;
  } row_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_stall_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0]  comb_q [$];
  logic [13:0] reg_q  [$];
  logic [CNT_W-1:0] e_lu = '0, e_ms = '0, e_fl = '0;
  logic e_me = 1'b0, e_pe = 1'b0;

  function automatic row_t mk(input logic [7:0] in_v, input logic [7:0] exp_c,
                              input logic [1:0] kind, input logic set_me, input logic set_pe);
    row_t r;
    r.in_v = in_v; r.exp_c = exp_c; r.kind = kind; r.set_me = set_me; r.set_pe = set_pe;
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic [7:0] comb_now();
    return {bus.dmem_req_o, bus.pc_we_o, bus.ifid_we_o, bus.ifid_flush_o, bus.idex_bubble_o,
            bus.idex_we_o, bus.exmem_we_o, bus.memwb_we_o};
  endfunction

  function automatic logic [13:0] regs_now();
    return {bus.loaduse_cnt_o, bus.memstall_cnt_o, bus.flush_cnt_o, bus.mem_err_o, bus.proto_err_o};
  endfunction

  task automatic set_inputs(input logic [7:0] in_v);
    rst                  = in_v[7];
    bus.hz_pcwrite_i     = in_v[6];
    bus.hz_stall_i       = in_v[5];
    bus.hz_noop_i        = in_v[4];
    bus.br_flush_i       = in_v[3];
    bus.exmem_memread_i  = in_v[2];
    bus.exmem_memwrite_i = in_v[1];
    bus.dmem_ack_i       = in_v[0];
  endtask

  // Drives one row and queues what the DUT must show now (comb) and after the next edge (regs).
  task automatic drive(input row_t r);
    set_inputs(r.in_v);
    comb_q.push_back(r.exp_c);
    if (r.in_v[7]) begin
      e_lu = '0; e_ms = '0; e_fl = '0; e_me = 1'b0; e_pe = 1'b0;
    end else begin
      case (r.kind)
        K_MEM:   e_ms = sat_inc(e_ms);
        K_LU:    e_lu = sat_inc(e_lu);
        K_BR:    e_fl = sat_inc(e_fl);
        default: ;
      endcase
      e_me = e_me | r.set_me;
      e_pe = e_pe | r.set_pe;
    end
    reg_q.push_back({e_lu, e_ms, e_fl, e_me, e_pe});
  endtask

  task automatic test_reset();
    row_t rows[$];
    logic [7:0] ec; logic [13:0] er;
    rows.push_back(mk(IN_RST,    C_IDLE, K_NONE, 1'b0, 1'b0));
    rows.push_back(mk(IN_RST_RD, C_IDLE, K_NONE, 1'b0, 1'b0));
    foreach (rows[i]) begin
      drive(rows[i]);
      #2; ec = comb_q.pop_front(); n_cmp++;
      $display("reset row%0d in=%b comb=%b", i, rows[i].in_v, comb_now());
      if (comb_now() !== ec) begin n_bad++; $display("FAIL reset_comb row%0d got=%b exp=%b", i, comb_now(), ec); end
      @(posedge clk); #1; er = reg_q.pop_front(); n_cmp++;
      if (regs_now() !== er) begin n_bad++; $display("FAIL reset_regs row%0d got=%h exp=%h", i, regs_now(), er); end
    end
  endtask

  task automatic test_load_use();
    row_t rows[$];
    logic [7:0] ec; logic [13:0] er;
    rows.push_back(mk(IN_IDLE, C_IDLE, K_NONE, 1'b0, 1'b0));
    rows.push_back(mk(IN_LU,   C_LU,   K_LU,   1'b0, 1'b0));
    rows.push_back(mk(IN_IDLE, C_IDLE, K_NONE, 1'b0, 1'b0));
    foreach (rows[i]) begin
      drive(rows[i]);
      #2; ec = comb_q.pop_front(); n_cmp++;
      $display("load_use row%0d in=%b comb=%b", i, rows[i].in_v, comb_now());
      if (comb_now() !== ec) begin n_bad++; $display("FAIL load_use_comb row%0d got=%b exp=%b", i, comb_now(), ec); end
      @(posedge clk); #1; er = reg_q.pop_front(); n_cmp++;
      if (regs_now() !== er) begin n_bad++; $display("FAIL load_use_regs row%0d got=%h exp=%h", i, regs_now(), er); end
    end
  endtask

  task automatic test_mem_wait();
    row_t rows[$];
    logic [7:0] ec; logic [13:0] er;
    for (int k = 0; k < 3; k++) rows.push_back(mk(IN_RD, C_FREEZE, K_MEM, 1'b0, 1'b0));
    rows.push_back(mk(IN_RD_ACK, C_ACK,  K_NONE, 1'b0, 1'b0));
    // Access gone after the ack: a controller left in WAIT would flag a protocol error here.
    rows.push_back(mk(IN_IDLE,   C_IDLE, K_NONE, 1'b0, 1'b0));
    rows.push_back(mk(IN_RD_ACK, C_ACK,  K_NONE, 1'b0, 1'b0));
    rows.push_back(mk(IN_IDLE,   C_IDLE, K_NONE, 1'b0, 1'b0));
    foreach (rows[i]) begin
      drive(rows[i]);
      #2; ec = comb_q.pop_front(); n_cmp++;
      $display("mem_wait row%0d in=%b comb=%b", i, rows[i].in_v, comb_now());
      if (comb_now() !== ec) begin n_bad++; $display("FAIL mem_wait_comb row%0d got=%b exp=%b", i, comb_now(), ec); end
      @(posedge clk); #1; er = reg_q.pop_front(); n_cmp++;
      if (regs_now() !== er) begin n_bad++; $display("FAIL mem_wait_regs row%0d got=%h exp=%h", i, regs_now(), er); end
    end
  endtask

  task automatic test_simultaneous();
    row_t rows[$];
    logic [7:0] ec; logic [13:0] er;
    rows.push_back(mk(IN_LU_BR,    C_LU,     K_LU,   1'b0, 1'b0));
    rows.push_back(mk(IN_LU_BR_RD, C_FREEZE, K_MEM,  1'b0, 1'b0));
    rows.push_back(mk(IN_LU_BR_AK, C_LU_ACK, K_LU,   1'b0, 1'b0));
    rows.push_back(mk(IN_IDLE,     C_IDLE,   K_NONE, 1'b0, 1'b0));
    foreach (rows[i]) begin
      drive(rows[i]);
      #2; ec = comb_q.pop_front(); n_cmp++;
      $display("simultaneous row%0d in=%b comb=%b", i, rows[i].in_v, comb_now());
      if (comb_now() !== ec) begin n_bad++; $display("FAIL simul_comb row%0d got=%b exp=%b", i, comb_now(), ec); end
      @(posedge clk); #1; er = reg_q.pop_front(); n_cmp++;
      if (regs_now() !== er) begin n_bad++; $display("FAIL simul_regs row%0d got=%h exp=%h", i, regs_now(), er); end
    end
  endtask

  task automatic test_branch();
    row_t rows[$];
    logic [7:0] ec; logic [13:0] er;
    rows.push_back(mk(IN_BR,     C_BR,   K_BR,   1'b0, 1'b0));
    rows.push_back(mk(IN_WR_ACK, C_ACK,  K_NONE, 1'b0, 1'b0));
    rows.push_back(mk(IN_BR,     C_BR,   K_BR,   1'b0, 1'b0));
    rows.push_back(mk(IN_IDLE,   C_IDLE, K_NONE, 1'b0, 1'b0));
    foreach (rows[i]) begin
      drive(rows[i]);
      #2; ec = comb_q.pop_front(); n_cmp++;
      $display("branch row%0d in=%b comb=%b", i, rows[i].in_v, comb_now());
      if (comb_now() !== ec) begin n_bad++; $display("FAIL branch_comb row%0d got=%b exp=%b", i, comb_now(), ec); end
      @(posedge clk); #1; er = reg_q.pop_front(); n_cmp++;
      if (regs_now() !== er) begin n_bad++; $display("FAIL branch_regs row%0d got=%h exp=%h", i, regs_now(), er); end
    end
  endtask

  task automatic test_timeout_protocol();
    row_t rows[$];
    logic [7:0] ec; logic [13:0] er;
    rows.push_back(mk(IN_RST, C_IDLE, K_NONE, 1'b0, 1'b0));
    // Edge 1 enters WAIT with count 1; the count reaches MAX_WAIT on edge MAX_WAIT, the flag follows one edge later.
    for (int k = 1; k <= MAX_WAIT + 2; k++)
      rows.push_back(mk(IN_RD, C_FREEZE, K_MEM, (k == MAX_WAIT + 1), 1'b0));
    rows.push_back(mk(IN_RD_ACK, C_ACK,   K_NONE, 1'b0, 1'b0));
    rows.push_back(mk(IN_IDLE,   C_IDLE,  K_NONE, 1'b0, 1'b0));
    rows.push_back(mk(IN_PROTO,  C_PROTO, K_LU,   1'b0, 1'b1));
    rows.push_back(mk(IN_IDLE,   C_IDLE,  K_NONE, 1'b0, 1'b0));
    rows.push_back(mk(IN_RST,    C_IDLE,  K_NONE, 1'b0, 1'b0));
    rows.push_back(mk(IN_RD,     C_FREEZE, K_MEM, 1'b0, 1'b0));
    rows.push_back(mk(IN_IDLE,   C_IDLE,  K_NONE, 1'b0, 1'b1));
    rows.push_back(mk(IN_IDLE,   C_IDLE,  K_NONE, 1'b0, 1'b0));
    foreach (rows[i]) begin
      drive(rows[i]);
      #2; ec = comb_q.pop_front(); n_cmp++;
      $display("timeout_proto row%0d in=%b comb=%b", i, rows[i].in_v, comb_now());
      if (comb_now() !== ec) begin n_bad++; $display("FAIL timeout_comb row%0d got=%b exp=%b", i, comb_now(), ec); end
      @(posedge clk); #1; er = reg_q.pop_front(); n_cmp++;
      if (regs_now() !== er) begin n_bad++; $display("FAIL timeout_regs row%0d got=%h exp=%h", i, regs_now(), er); end
    end
  endtask

  task automatic test_reset_mid_wait();
    row_t rows[$];
    logic [7:0] ec; logic [13:0] er;
    rows.push_back(mk(IN_BR,     C_BR,     K_BR,   1'b0, 1'b0));
    rows.push_back(mk(IN_RD,     C_FREEZE, K_MEM,  1'b0, 1'b0));
    rows.push_back(mk(IN_RD,     C_FREEZE, K_MEM,  1'b0, 1'b0));
    rows.push_back(mk(IN_RST_RD, C_IDLE,   K_NONE, 1'b0, 1'b0));
    rows.push_back(mk(IN_IDLE,   C_IDLE,   K_NONE, 1'b0, 1'b0));
    rows.push_back(mk(IN_RD,     C_FREEZE, K_MEM,  1'b0, 1'b0));
    rows.push_back(mk(IN_RD_ACK, C_ACK,    K_NONE, 1'b0, 1'b0));
    foreach (rows[i]) begin
      drive(rows[i]);
      #2; ec = comb_q.pop_front(); n_cmp++;
      $display("reset_mid_wait row%0d in=%b comb=%b", i, rows[i].in_v, comb_now());
      if (comb_now() !== ec) begin n_bad++; $display("FAIL midwait_comb row%0d got=%b exp=%b", i, comb_now(), ec); end
      @(posedge clk); #1; er = reg_q.pop_front(); n_cmp++;
      if (regs_now() !== er) begin n_bad++; $display("FAIL midwait_regs row%0d got=%h exp=%h", i, regs_now(), er); end
    end
  endtask

  task automatic test_saturation();
    row_t rows[$];
    logic [7:0] ec; logic [13:0] er;
    rows.push_back(mk(IN_RST, C_IDLE, K_NONE, 1'b0, 1'b0));
    for (int k = 0; k < 20; k++) rows.push_back(mk(IN_LU, C_LU, K_LU, 1'b0, 1'b0));
    rows.push_back(mk(IN_IDLE, C_IDLE, K_NONE, 1'b0, 1'b0));
    foreach (rows[i]) begin
      drive(rows[i]);
      #2; ec = comb_q.pop_front(); n_cmp++;
      $display("saturation row%0d in=%b comb=%b", i, rows[i].in_v, comb_now());
      if (comb_now() !== ec) begin n_bad++; $display("FAIL sat_comb row%0d got=%b exp=%b", i, comb_now(), ec); end
      @(posedge clk); #1; er = reg_q.pop_front(); n_cmp++;
      if (regs_now() !== er) begin n_bad++; $display("FAIL sat_regs row%0d got=%h exp=%h", i, regs_now(), er); end
    end
    n_cmp++;
    if (bus.loaduse_cnt_o !== 4'd15) begin
      n_bad++; $display("FAIL sat_hold got=%0d exp=15", bus.loaduse_cnt_o);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    set_inputs(IN_RST);
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_mem_wait();
    test_simultaneous();
    test_branch();
    test_timeout_protocol();
    test_reset_mid_wait();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
